// File: rtl/dmem_responder_pkg.sv
// Shared CPU definitions for the data-memory responder: FSM states, LW/SW
// opcodes and the captured-request record.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   localparam logic [3:0] OP_LW = 4'b1000;
   localparam logic [3:0] OP_SW = 4'b1001;

   typedef struct packed {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
   } dmem_req_t;

   // Halfword access is misaligned when the byte-address LSB is set
   function automatic logic misaligned(input logic [15:0] addr);
      return addr[0];
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port 16-bit RAM; read data registered, contents never reset.
module dmem_array #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [15:0]       wdata_i,
   output logic [15:0]       rdata_o
);

   logic [15:0] mem_q [2**ADDR_W];
   logic [15:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) mem_q[addr_i] <= wdata_i;
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for LW/SW. Optional misaligned-access
// error reporting is enabled with `define DMEM_MISALIGN_ERR_EN.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err
);

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   dmem_state_e state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   dmem_req_t   req_q, req_d, cur;
   logic        accept, cur_err, rsp_bad;
   logic        mem_en, mem_we;
   logic [15:0] mem_rdata;
   logic        unused_addr;

   assign accept = req_valid & req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = (LATENCY == 1) ? RESP : BUSY;
         BUSY:    if (cnt_q == 4'd1) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == RESP);
   end

   always_comb begin
      cnt_d = 4'd0;
      if (state_q == IDLE && accept) cnt_d = CNT_LOAD;
      else if (state_q == BUSY)      cnt_d = cnt_q - 4'd1;
      req_d = accept ? '{wr: req_wr, addr: req_addr, wdata: req_wdata} : req_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 4'd0;
         req_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         req_q <= req_d;
      end
   end

   // With LATENCY==1 the RAM is accessed on the accepting edge, so it must
   // see the live request rather than the not-yet-captured copy.
   assign cur = (state_q == IDLE) ? '{wr: req_wr, addr: req_addr, wdata: req_wdata} : req_q;

`ifdef DMEM_MISALIGN_ERR_EN
   assign cur_err = misaligned(cur.addr);
   assign rsp_bad = misaligned(req_q.addr);
`else
   assign cur_err = 1'b0;
   assign rsp_bad = 1'b0;
`endif

   assign mem_en = rst_n & (state_q != RESP) & (state_d == RESP);
   assign mem_we = cur.wr & ~cur_err;

   dmem_array #(.ADDR_W(ADDR_W)) u_array (
      .clk     (clk),
      .en_i    (mem_en),
      .we_i    (mem_we),
      .addr_i  (cur.addr[ADDR_W:1]),
      .wdata_i (cur.wdata),
      .rdata_o (mem_rdata)
   );

   assign rsp_err   = rsp_valid & rsp_bad;
   assign rsp_rdata = (rsp_valid & ~req_q.wr & ~rsp_bad) ? mem_rdata : 16'h0000;

   // Upper address bits and the alignment bit are intentionally dropped
   assign unused_addr = ^{cur.addr, req_q.addr};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: LATENCY=4 instance for function/timing/reset,
// LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_wr;
   logic [15:0] req_addr, req_wdata;
   logic        req_ready, rsp_valid, rsp_err;
   logic [15:0] rsp_rdata;

   logic        v1, wr1;
   logic [15:0] a1, d1;
   logic        rdy1, rv1, er1;
   logic [15:0] rd1;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(10), .LATENCY(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dmem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(v1), .req_ready(rdy1), .req_wr(wr1),
      .req_addr(a1), .req_wdata(d1),
      .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(er1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   // One transaction on the LATENCY=4 instance; lat counts cycles after acceptance
   task automatic xact(input logic wr, input logic [15:0] a, input logic [15:0] d,
                       output logic [15:0] rd, output logic er, output int lat);
      @(negedge clk);
      req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rd = rsp_rdata;
      er = rsp_err;
      if (lat >= 20) chk("rsp_timeout", 32'(lat), 32'd4);
   endtask

   typedef struct { logic wr; logic [15:0] a; logic [15:0] d; logic [15:0] exp; } vec_t;

   initial begin
      logic [15:0] rd;
      logic        er;
      int          lat;
      logic        seen;
      vec_t        b2b [4];

      rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
      v1 = 1'b0; wr1 = 1'b0; a1 = '0; d1 = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", req_ready, 1'b1);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rdata", rsp_rdata, 16'h0);
      chk("rst_err", rsp_err, 1'b0);
      rst_n = 1'b1;

      // store then load same word
      xact(1'b1, 16'h000a, 16'h1234, rd, er, lat);
      chk("st_lat", 32'(lat), 32'd4);
      chk("st_rdata_zero", rd, 16'h0);
      chk("st_err", er, 1'b0);
      xact(1'b0, 16'h000a, 16'h0, rd, er, lat);
      chk("ld_rdata", rd, 16'h1234);
      chk("ld_err", er, 1'b0);
      chk("ld_lat", 32'(lat), 32'd4);

      // cycle-exact timing of a single load
      @(negedge clk);
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h000a;
      chk("t0_ready", req_ready, 1'b1);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         chk($sformatf("t%0d_ready", c), req_ready, (c == 5));
         chk($sformatf("t%0d_valid", c), rsp_valid, (c == 4));
         chk($sformatf("t%0d_rdata", c), rsp_rdata, (c == 4) ? 16'h1234 : 16'h0);
      end

`ifdef DMEM_MISALIGN_ERR_EN
      xact(1'b1, 16'h000b, 16'hbeef, rd, er, lat);
      chk("mis_st_err", er, 1'b1);
      chk("mis_st_rdata", rd, 16'h0);
      xact(1'b0, 16'h000a, 16'h0, rd, er, lat);
      chk("mis_no_commit", rd, 16'h1234);
      chk("mis_ok_err", er, 1'b0);
`else
      xact(1'b0, 16'h000b, 16'h0, rd, er, lat);
      chk("odd_ld_word5", rd, 16'h1234);
      chk("odd_ld_err", er, 1'b0);
`endif

      // wrap-around modulo depth and top word
      xact(1'b1, 16'h0802, 16'h00aa, rd, er, lat);
      xact(1'b0, 16'h0002, 16'h0, rd, er, lat);
      chk("wrap_ld", rd, 16'h00aa);
      xact(1'b1, 16'h07fe, 16'hffff, rd, er, lat);
      xact(1'b0, 16'hfffe, 16'h0, rd, er, lat);
      chk("top_word", rd, 16'hffff);

      // LATENCY=1 back-to-back with req_valid held high
      b2b[0] = '{1'b1, 16'h0000, 16'h1111, 16'h0000};
      b2b[1] = '{1'b1, 16'h0002, 16'h2222, 16'h0000};
      b2b[2] = '{1'b0, 16'h0000, 16'h0000, 16'h1111};
      b2b[3] = '{1'b0, 16'h0002, 16'h0000, 16'h2222};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         v1 = 1'b1; wr1 = b2b[i].wr; a1 = b2b[i].a; d1 = b2b[i].d;
         chk($sformatf("b2b%0d_acc_ready", i), rdy1, 1'b1);
         chk($sformatf("b2b%0d_acc_valid", i), rv1, 1'b0);
         @(negedge clk);
         chk($sformatf("b2b%0d_rsp_ready", i), rdy1, 1'b0);
         chk($sformatf("b2b%0d_rsp_valid", i), rv1, 1'b1);
         chk($sformatf("b2b%0d_rdata", i), rd1, b2b[i].exp);
      end
      @(negedge clk);
      v1 = 1'b0;

      // reset mid-store must drop the request and not commit
      xact(1'b1, 16'h000c, 16'h0777, rd, er, lat);
      @(negedge clk);
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h000c; req_wdata = 16'h5555;
      seen = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      seen |= rsp_valid;
      @(negedge clk);
      rst_n = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         seen |= rsp_valid;
      end
      chk("rst_mid_ready", req_ready, 1'b1);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         seen |= rsp_valid;
      end
      chk("rst_mid_no_rsp", seen, 1'b0);
      xact(1'b0, 16'h000c, 16'h0, rd, er, lat);
      chk("rst_mid_no_commit", rd, 16'h0777);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width (memory depth 2^ADDR_W 16-bit words).
REQ-002 SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to response (legal range 1..15).
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have req_valid  input  1  requester (LW/SW issue stage) presents a request.
REQ-006 SHALL have req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have req_wr  input  1  1 = store (SW), 0 = load (LW).
REQ-008 SHALL have req_addr  input  16  byte address as computed by the ALU; bit 0 is the alignment bit.
REQ-009 SHALL have req_wdata  input  16  store data.
REQ-010 SHALL have rsp_valid  output  1  one-cycle response pulse.
REQ-011 SHALL have rsp_rdata  output  16  load data; valid only with rsp_valid.
REQ-012 SHALL have rsp_err  output  1  misaligned-access error; valid only with rsp_valid.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-014 SHALL drive req_ready=1 only in IDLE.
REQ-015 SHALL accept on a rising edge where req_valid & req_ready; capture req_wr, req_addr, req_wdata at that edge; ignore req_* at all other times.
REQ-016 On acceptance, SHALL enter RESP directly if LATENCY==1, else enter BUSY with down-counter loaded to LATENCY-1.
REQ-017 In BUSY, SHALL decrement the counter each edge and enter RESP on the edge where the counter equals 1.
REQ-018 SHALL assert rsp_valid for exactly one cycle (state RESP), the LATENCY-th cycle after the acceptance cycle; there is no response backpressure.
REQ-019 SHALL word-index memory with captured req_addr[ADDR_W:1]; upper address bits are ignored (wrap-around modulo depth).
REQ-020 SHALL commit a store, and register load data from the array, on the edge entering RESP.
REQ-021 SHALL drive rsp_rdata=0 for stores and whenever rsp_valid=0.
REQ-022 SHALL return from RESP to IDLE unconditionally; next acceptance is possible one cycle after rsp_valid (throughput one request per LATENCY+1 cycles).
REQ-023 A load following a store to the same word SHALL return the stored value.

Reset
REQ-024 While rst_n=0, SHALL force state IDLE, counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-025 Reset asserted mid-request SHALL drop the request with no response; a store not yet in RESP SHALL NOT commit.
REQ-026 Memory array contents SHALL NOT be reset.

Configuration
REQ-027 With DMEM_MISALIGN_ERR_EN defined, a captured address with bit 0 = 1 SHALL give rsp_err=1, suppress the store, and return rsp_rdata=0.
REQ-028 Without DMEM_MISALIGN_ERR_EN, address bit 0 SHALL be ignored and rsp_err SHALL be tied 0.

Structure
REQ-029 SHALL place the FSM state enum and the LW/SW opcode constants (4'b1000, 4'b1001) in the shared CPU package.
REQ-030 SHALL instantiate one sub-module, dmem_array (synchronous single-port 16-bit RAM).

Verification
REQ-031 Store 0x1234 to addr 0x000a, then load 0x000a -> load rsp_rdata=0x1234, rsp_err=0.
REQ-032 LATENCY=4, load accepted at cycle 0 -> rsp_valid high only at cycle 4; req_ready low during cycles 1-4.
REQ-033 LATENCY=1, req_valid held high with back-to-back loads of 0x0000 and 0x0002 -> acceptances at cycles 0 and 2, responses at cycles 1 and 3.
REQ-034 With macro: store 0xbeef to 0x000b -> rsp_err=1; load 0x000a returns its previous value. Without macro: load 0x000b returns the contents of word 5.
REQ-035 ADDR_W=10: store 0x00aa to 0x0802, load 0x0002 -> 0x00aa (wrap-around).
REQ-036 Store 0x5555 to 0x000c, assert rst_n=0 at cycle 2 -> no rsp_valid; a later load of 0x000c returns the old value.
